// File: rtl/cpu_program_loader.sv
// rtl/cpu_program_loader.sv - byte-stream loader writing framed programs into CPU memory.
// Optional idle-gap abort inside a frame: define LOADER_TIMEOUT_EN.
module cpu_program_loader #(
    parameter int          ADDR_W         = 4,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]          mem_wdata_q, mem_wdata_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [7:0]          sum_q, sum_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                accept;
`ifdef LOADER_TIMEOUT_EN
    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [GAP_W-1:0]    gap_q, gap_d;
`endif

    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d     = state_q;
        in_ready_d  = 1'b1;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_reset_d = cpu_reset_q;
        done_d      = done_q;
        err_d       = err_q;
        sum_d       = sum_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
`ifdef LOADER_TIMEOUT_EN
        gap_d       = '0;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (accept && in_data == SYNC_BYTE) begin
                    state_d     = S_ADDR;
                    sum_d       = 8'h00;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    cpu_reset_d = 1'b1;
                end
            end
            S_ADDR: begin
                if (accept) begin
                    if ((in_data >> ADDR_W) != '0) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        ptr_d   = ADDR_W'(in_data);
                        sum_d   = sum_q + in_data;
                        state_d = S_LEN;
                    end
                end
            end
            S_LEN: begin
                if (accept) begin
                    if (in_data == 8'h00 || int'(in_data) > DEPTH) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d   = CNT_W'(in_data);
                        sum_d   = sum_q + in_data;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ptr_q;
                    mem_wdata_d = in_data;
                    ptr_d       = ptr_q + 1'b1;
                    sum_d       = sum_q + in_data;
                    cnt_d       = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (8'(sum_q + in_data) == 8'h00) begin
                        state_d     = S_DONE;
                        done_d      = 1'b1;
                        cpu_reset_d = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef LOADER_TIMEOUT_EN
        // Gap is measured only while a frame is open; any accepted byte restarts it.
        if (busy_q && !accept && !in_valid) begin
            if (gap_q == GAP_W'(TIMEOUT_CYCLES - 1)) begin
                state_d     = S_ERR;
                err_d       = 1'b1;
                cpu_reset_d = 1'b1;
            end else begin
                gap_d = gap_q + 1'b1;
            end
        end
`endif
        busy_d = (state_d == S_ADDR) || (state_d == S_LEN) ||
                 (state_d == S_DATA) || (state_d == S_CSUM);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            sum_q       <= 8'h00;
            ptr_q       <= '0;
            cnt_q       <= '0;
`ifdef LOADER_TIMEOUT_EN
            gap_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            sum_q       <= sum_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
`ifdef LOADER_TIMEOUT_EN
            gap_q       <= gap_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_reset = cpu_reset_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
endmodule
